// File: rtl/uart_cmd_parser_if.sv
// Bundle of the two handshakes around the command parser.
//   Receive side : rx_data (8), rx_data_ready (byte strobe), rx_endofpacket (idle strobe)
//   Write side   : wr_valid, wr_ready, wr_addr (8), wr_data (8)
// Modports:
//   master : the environment (UART receiver + register file); drives the rx
//            strobes and wr_ready, observes the write request.
//   slave  : the parser; consumes the rx strobes and wr_ready, drives the
//            write request.
interface uart_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       rx_endofpacket;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    output rx_data, rx_data_ready, rx_endofpacket, wr_ready,
    input  wr_valid, wr_addr, wr_data
  );

  modport slave (
    input  rx_data, rx_data_ready, rx_endofpacket, wr_ready,
    output wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Frames the UART byte stream into command packets
//   SYNC, ADDR, LEN, LEN payload bytes, CHK
// buffers the payload, verifies CHK = XOR(ADDR, LEN, payload) and, on a good
// frame, replays the payload as writes (base+i, payload[i]) on a valid/ready bus.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   bus        uart_cmd_parser_if.slave: rx byte/eop strobes in, write request out
//   busy       parser is not idle
//   frame_ok   pulse: last write of a good frame accepted (or good empty frame)
//   chk_err    pulse: checksum mismatch, frame dropped
//   len_err    pulse: LEN > MAX_LEN, frame dropped
//   abort_err  pulse: line went idle mid-frame, frame dropped
//   overrun    pulse: byte arrived while draining, byte dropped
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_cmd_parser_if.slave  bus,
  output logic              busy,
  output logic              frame_ok,
  output logic              chk_err,
  output logic              len_err,
  output logic              abort_err,
  output logic              overrun
);

  localparam int         IDXW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t     state;
  logic [7:0] base;
  logic [7:0] len;
  logic [7:0] idx;
  logic [7:0] rd;
  logic [7:0] acc;
  logic       wr_valid_r;
  logic [7:0] wr_addr_r;
  logic [7:0] wr_data_r;

  // Payload buffer: plain array, written while collecting, read through the
  // wr_data register so it maps onto block RAM with a registered read port.
  logic [7:0] buf_mem [MAX_LEN];

  logic       byte_in;
  logic       eop_in;
  logic [7:0] din;
  logic       xfer;
  logic [7:0] rd_next;

  assign byte_in = bus.rx_data_ready;
  assign eop_in  = bus.rx_endofpacket;
  assign din     = bus.rx_data;
  assign xfer    = wr_valid_r & bus.wr_ready;
  assign rd_next = rd + 8'd1;

  assign bus.wr_valid = wr_valid_r;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && byte_in) begin
      buf_mem[idx[IDXW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      base       <= '0;
      len        <= '0;
      idx        <= '0;
      rd         <= '0;
      acc        <= '0;
      wr_valid_r <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      frame_ok   <= 1'b0;
      chk_err    <= 1'b0;
      len_err    <= 1'b0;
      abort_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses.
      frame_ok  <= 1'b0;
      chk_err   <= 1'b0;
      len_err   <= 1'b0;
      abort_err <= 1'b0;
      overrun   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (byte_in && din == SYNC_BYTE) begin
            acc   <= '0;
            state <= S_ADDR;
          end
        end

        // In the collecting states a byte strobe wins over a coincident eop.
        S_ADDR: begin
          if (byte_in) begin
            base  <= din;
            acc   <= acc ^ din;
            state <= S_LEN;
          end else if (eop_in) begin
            abort_err <= 1'b1;
            state     <= S_IDLE;
          end
        end

        S_LEN: begin
          if (byte_in) begin
            acc <= acc ^ din;
            if ({1'b0, din} > MAX_LEN_W) begin
              len_err <= 1'b1;
              state   <= S_IDLE;
            end else if (din == 8'd0) begin
              len   <= 8'd0;
              state <= S_CHK;
            end else begin
              len   <= din;
              idx   <= '0;
              state <= S_PAYLOAD;
            end
          end else if (eop_in) begin
            abort_err <= 1'b1;
            state     <= S_IDLE;
          end
        end

        S_PAYLOAD: begin
          if (byte_in) begin
            acc <= acc ^ din;
            idx <= idx + 8'd1;
            if (idx == len - 8'd1) begin
              state <= S_CHK;
            end
          end else if (eop_in) begin
            abort_err <= 1'b1;
            state     <= S_IDLE;
          end
        end

        S_CHK: begin
          if (byte_in) begin
            if (din == acc) begin
              if (len == 8'd0) begin
                frame_ok <= 1'b1;
                state    <= S_IDLE;
              end else begin
                // Preload the first write so wr_valid rises with valid data.
                rd         <= '0;
                wr_valid_r <= 1'b1;
                wr_addr_r  <= base;
                wr_data_r  <= buf_mem[{IDXW{1'b0}}];
                state      <= S_DRAIN;
              end
            end else begin
              chk_err <= 1'b1;
              state   <= S_IDLE;
            end
          end else if (eop_in) begin
            abort_err <= 1'b1;
            state     <= S_IDLE;
          end
        end

        S_DRAIN: begin
          if (xfer) begin
            if (rd == len - 8'd1) begin
              wr_valid_r <= 1'b0;
              frame_ok   <= 1'b1;
              state      <= S_IDLE;
            end else begin
              rd        <= rd_next;
              wr_addr_r <= wr_addr_r + 8'd1;
              wr_data_r <= buf_mem[rd_next[IDXW-1:0]];
            end
          end
          // Only one pulse per cycle: completion outranks a dropped byte.
          if (byte_in && !(xfer && rd == len - 8'd1)) begin
            overrun <= 1'b1;
          end
        end

        default: begin
          state      <= S_IDLE;
          wr_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames with literal
// expectations, then a randomized byte stream checked every cycle against a
// queue-based frame model.
module tb_uart_cmd_parser;
  localparam int MAX_LEN = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, frame_ok, chk_err, len_err, abort_err, overrun;

  uart_cmd_parser_if bus();

  uart_cmd_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy),
    .frame_ok(frame_ok), .chk_err(chk_err), .len_err(len_err),
    .abort_err(abort_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // ---------------- reference model ----------------
  // collecting: inside a frame, frame_q holds every byte after SYNC.
  // pend_q: writes still to be offered on the bus, {addr, data}.
  bit         collecting;
  logic [7:0] frame_q[$];
  logic [15:0] pend_q[$];
  logic       e_fok, e_chk, e_len, e_abt, e_ovr;

  task automatic model_step();
    int n;
    int flen;
    logic [7:0] x;
    e_fok = 0; e_chk = 0; e_len = 0; e_abt = 0; e_ovr = 0;
    if (!rst_n) begin
      collecting = 0;
      frame_q.delete();
      pend_q.delete();
      return;
    end
    if (pend_q.size() > 0) begin
      if (bus.wr_ready) begin
        void'(pend_q.pop_front());
        if (pend_q.size() == 0) e_fok = 1;
      end
      if (bus.rx_data_ready && !e_fok) e_ovr = 1;
    end else if (collecting) begin
      if (bus.rx_data_ready) begin
        frame_q.push_back(bus.rx_data);
        n = frame_q.size();
        if (n >= 2) begin
          flen = int'(frame_q[1]);
          if (n == 2 && flen > MAX_LEN) begin
            e_len = 1;
            collecting = 0;
          end else if (n == flen + 3) begin
            x = 8'h00;
            for (int i = 0; i < n - 1; i++) x = x ^ frame_q[i];
            if (x == frame_q[n-1]) begin
              if (flen == 0) e_fok = 1;
              for (int i = 0; i < flen; i++)
                pend_q.push_back({8'(frame_q[0] + 8'(i)), frame_q[2+i]});
            end else begin
              e_chk = 1;
            end
            collecting = 0;
          end
        end
      end else if (bus.rx_endofpacket) begin
        e_abt = 1;
        collecting = 0;
      end
    end else if (bus.rx_data_ready && bus.rx_data == 8'hA5) begin
      collecting = 1;
      frame_q.delete();
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_outputs();
    check("pulses{ok,chk,len,abort,ovr}",
          16'({frame_ok, chk_err, len_err, abort_err, overrun}),
          16'({e_fok, e_chk, e_len, e_abt, e_ovr}));
    check("wr_valid", 16'(bus.wr_valid), 16'(pend_q.size() > 0));
    check("busy", 16'(busy), 16'(collecting || pend_q.size() > 0));
    if (pend_q.size() > 0) begin
      check("wr_addr", 16'(bus.wr_addr), 16'(pend_q[0][15:8]));
      check("wr_data", 16'(bus.wr_data), 16'(pend_q[0][7:0]));
    end
  endtask

  // ---------------- stimulus helpers ----------------
  int ready_mode = 0;   // 0 hold, 1 toggle, 2 random
  logic [15:0] wlog[$];
  int n_fok, n_chke, n_lene, n_abt, n_ovr;

  task automatic clear_log();
    wlog.delete();
    n_fok = 0; n_chke = 0; n_lene = 0; n_abt = 0; n_ovr = 0;
  endtask

  task automatic tick();
    logic xf;
    logic [15:0] aw;
    case (ready_mode)
      1: bus.wr_ready = ~bus.wr_ready;
      2: bus.wr_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
    xf = rst_n && bus.wr_valid && bus.wr_ready;
    aw = {bus.wr_addr, bus.wr_data};
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
    if (xf) begin
      wlog.push_back(aw);
      $display("write addr=%02h data=%02h", aw[15:8], aw[7:0]);
    end
    n_fok += int'(frame_ok); n_chke += int'(chk_err); n_lene += int'(len_err);
    n_abt += int'(abort_err); n_ovr += int'(overrun);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_data_ready = 1'b1;
    tick();
    bus.rx_data_ready = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b[$]);
    foreach (b[i]) send_byte(b[i]);
  endtask

  task automatic send_eop();
    bus.rx_endofpacket = 1'b1;
    tick();
    bus.rx_endofpacket = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int c = 0;
    while (busy && c < max_cycles) begin
      tick();
      c++;
    end
    check("idle_within_budget", 16'(busy), 16'd0);
  endtask

  task automatic check_writes(input string name, input logic [15:0] e[$]);
    check($sformatf("%s write count", name), 16'(wlog.size()), 16'(e.size()));
    foreach (e[i])
      check($sformatf("%s write %0d", name, i), (i < wlog.size()) ? wlog[i] : 16'hxxxx, e[i]);
  endtask

  // ---------------- test sequence ----------------
  logic [7:0]  fb[$];
  logic [15:0] ew[$];
  logic [7:0]  x;
  int          kind, flen, cut, gap;

  initial begin
    bus.rx_data = 8'h00;
    bus.rx_data_ready = 1'b0;
    bus.rx_endofpacket = 1'b0;
    bus.wr_ready = 1'b1;
    clear_log();
    collecting = 0;

    // Reset state
    repeat (3) tick();
    check("reset wr_valid", 16'(bus.wr_valid), 16'd0);
    check("reset wr_addr", 16'(bus.wr_addr), 16'd0);
    check("reset wr_data", 16'(bus.wr_data), 16'd0);
    check("reset busy", 16'(busy), 16'd0);
    rst_n = 1'b1;
    tick();

    // 1: basic three-byte frame (checksum 10^03^11^22^33 = 13)
    clear_log();
    send_bytes('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13});
    wait_idle(50);
    ew = '{16'h1011, 16'h1122, 16'h1233};
    check_writes("t1", ew);
    check("t1 frame_ok count", 16'(n_fok), 16'd1);
    check("t1 error count", 16'(n_chke + n_lene + n_abt + n_ovr), 16'd0);

    // 2: checksum mismatch (expected 03, got 00)
    clear_log();
    send_bytes('{8'hA5, 8'h10, 8'h02, 8'hAA, 8'hBB, 8'h00});
    tick();
    check("t2 chk_err count", 16'(n_chke), 16'd1);
    check("t2 write count", 16'(wlog.size()), 16'd0);
    check("t2 busy after", 16'(busy), 16'd0);

    // 3: oversize LEN, then a good one-byte frame
    clear_log();
    send_bytes('{8'hA5, 8'h00, 8'h11});
    tick();
    check("t3 len_err count", 16'(n_lene), 16'd1);
    send_bytes('{8'hA5, 8'h30, 8'h01, 8'h5A, 8'h6B});
    wait_idle(50);
    ew = '{16'h305A};
    check_writes("t3", ew);
    check("t3 frame_ok count", 16'(n_fok), 16'd1);

    // 4: address wrap with a toggling consumer
    clear_log();
    ready_mode = 1;
    send_bytes('{8'hA5, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFD});
    wait_idle(50);
    ready_mode = 0;
    bus.wr_ready = 1'b1;
    ew = '{16'hFE01, 16'hFF02, 16'h0003};
    check_writes("t4", ew);
    check("t4 frame_ok count", 16'(n_fok), 16'd1);

    // 5: line idle mid-payload, then a good frame
    clear_log();
    send_bytes('{8'hA5, 8'h20, 8'h04, 8'h01, 8'h02});
    send_eop();
    check("t5 abort count", 16'(n_abt), 16'd1);
    check("t5 busy after abort", 16'(busy), 16'd0);
    send_bytes('{8'hA5, 8'h40, 8'h02, 8'h07, 8'h08, 8'h4D});
    wait_idle(50);
    ew = '{16'h4007, 16'h4108};
    check_writes("t5", ew);

    // 6: overrun while stalled, then reset mid-drain
    clear_log();
    bus.wr_ready = 1'b0;
    send_bytes('{8'hA5, 8'h50, 8'h02, 8'h01, 8'h02, 8'h51});
    tick(); tick();
    send_byte(8'h55);
    tick();
    check("t6 overrun count", 16'(n_ovr), 16'd1);
    bus.wr_ready = 1'b1;
    wait_idle(50);
    ew = '{16'h5001, 16'h5102};
    check_writes("t6", ew);
    check("t6 frame_ok count", 16'(n_fok), 16'd1);
    clear_log();
    bus.wr_ready = 1'b0;
    send_bytes('{8'hA5, 8'h50, 8'h02, 8'h01, 8'h02, 8'h51});
    tick();
    check("t6 draining before reset", 16'(bus.wr_valid), 16'd1);
    rst_n = 1'b0;
    #1;
    check("t6 wr_valid async drop", 16'(bus.wr_valid), 16'd0);
    check("t6 busy async drop", 16'(busy), 16'd0);
    tick();
    rst_n = 1'b1;
    bus.wr_ready = 1'b1;
    repeat (3) tick();
    check("t6 no writes after reset", 16'(wlog.size()), 16'd0);

    // Randomized stream: good frames, bad checksums, oversize LEN, aborts,
    // noise bytes and eops between frames, varying consumer behaviour.
    for (int f = 0; f < 80; f++) begin
      kind = $urandom_range(0, 9);
      ready_mode = $urandom_range(0, 2);
      if (ready_mode == 0) bus.wr_ready = 1'b1;
      flen = (kind == 0) ? $urandom_range(MAX_LEN + 1, 255) : $urandom_range(0, MAX_LEN);
      fb.delete();
      fb.push_back(8'hA5);
      fb.push_back(8'($urandom_range(0, 255)));
      fb.push_back(8'(flen));
      if (kind != 0) begin
        for (int i = 0; i < flen; i++) fb.push_back(8'($urandom_range(0, 255)));
        x = 8'h00;
        for (int i = 1; i < fb.size(); i++) x = x ^ fb[i];
        if (kind == 1) x = x ^ 8'(1 << $urandom_range(0, 7));
        fb.push_back(x);
      end
      cut = (kind == 2) ? $urandom_range(2, fb.size() - 1) : fb.size();
      for (int i = 0; i < cut; i++) begin
        send_byte(fb[i]);
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick();
      end
      if (kind == 2) send_eop();
      gap = $urandom_range(0, 12);
      for (int g = 0; g < gap; g++) begin
        bus.rx_data = 8'($urandom_range(0, 255));
        bus.rx_data_ready = ($urandom_range(0, 5) == 0);
        bus.rx_endofpacket = ($urandom_range(0, 7) == 0);
        tick();
        bus.rx_data_ready = 1'b0;
        bus.rx_endofpacket = 1'b0;
      end
    end
    ready_mode = 0;
    bus.wr_ready = 1'b1;
    bus.rx_endofpacket = 1'b1;
    tick();
    bus.rx_endofpacket = 1'b0;
    wait_idle(400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
